// File: rtl/modexp_mont.sv
// Bit-serial radix-2 Montgomery modular exponentiation, C = M^E mod P, left-to-right square-and-multiply.
// Define MODEXP_CT_EN for constant-time operation (MUL runs for every exponent bit, result discarded on zero bits).
module modexp_mont #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] m,
    input  logic [WIDTH-1:0] const_r2,
    output logic [WIDTH-1:0] c,
    output logic             eoc,
    output logic             done,
    output logic             busy,
    output logic             err
);

`ifdef MODEXP_CT_EN
    localparam bit CT = 1'b1;
`else
    localparam bit CT = 1'b0;
`endif

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int UW = WIDTH + 2;

    typedef enum logic [2:0] {
        IDLE, CHECK, TOMONT, INITX, SQR, MUL, FROMMONT, FIN
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  p_q, p_d, e_q, e_d, m_q, m_d, r2_q, r2_d;
    logic [WIDTH-1:0]  mbar_q, mbar_d, x_q, x_d;
    logic [UW-1:0]     u_q, u_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [WIDTH-1:0]  c_q, c_d;
    logic              eoc_q, eoc_d, done_q, done_d, busy_q, busy_d, err_q, err_d;

    logic [WIDTH-1:0]  op_a, op_b;
    logic              a_bit, e_bit, last, bad_op;
    logic [UW-1:0]     u_add, u_odd, u_step, u_fin;
    logic [WIDTH-1:0]  res;

    // Operand selection for the Montgomery product running in the current state
    always_comb begin
        op_a = '0;
        op_b = '0;
        case (state_q)
            TOMONT:   begin op_a = m_q;          op_b = r2_q;   end
            INITX:    begin op_a = WIDTH'(1);    op_b = r2_q;   end
            SQR:      begin op_a = x_q;          op_b = x_q;    end
            MUL:      begin op_a = x_q;          op_b = mbar_q; end
            FROMMONT: begin op_a = x_q;          op_b = WIDTH'(1); end
            default:  begin op_a = '0;           op_b = '0;     end
        endcase
    end

    assign a_bit  = |(op_a & (WIDTH'(1) << cnt_q));
    assign e_bit  = |(e_q & (WIDTH'(1) << bit_q));
    assign last   = (cnt_q == CW'(WIDTH));
    assign bad_op = ~p_q[0] | (p_q < WIDTH'(3)) | (r2_q >= p_q);

    // u stays below 2P, so the sum u + b + P fits in WIDTH+2 bits
    assign u_add  = u_q + (a_bit ? {2'b00, op_b} : '0);
    assign u_odd  = u_add + (u_add[0] ? {2'b00, p_q} : '0);
    assign u_step = u_odd >> 1;
    assign u_fin  = (u_q >= {2'b00, p_q}) ? (u_q - {2'b00, p_q}) : u_q;
    assign res    = WIDTH'(u_fin);

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        e_d     = e_q;
        m_d     = m_q;
        r2_d    = r2_q;
        mbar_d  = mbar_q;
        x_d     = x_q;
        u_d     = u_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        c_d     = c_q;
        eoc_d   = 1'b0;
        done_d  = done_q;
        busy_d  = busy_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    p_d     = p;
                    e_d     = e;
                    m_d     = m;
                    r2_d    = const_r2;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                u_d   = '0;
                cnt_d = '0;
                if (bad_op) begin
                    err_d   = 1'b1;
                    c_d     = '0;
                    state_d = FIN;
                end else begin
                    state_d = TOMONT;
                end
            end
            TOMONT, INITX, SQR, MUL, FROMMONT: begin
                if (!last) begin
                    u_d   = u_step;
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    u_d   = '0;
                    cnt_d = '0;
                    case (state_q)
                        TOMONT: begin
                            mbar_d  = res;
                            state_d = INITX;
                        end
                        INITX: begin
                            x_d     = res;
                            bit_d   = BW'(WIDTH - 1);
                            state_d = SQR;
                        end
                        SQR: begin
                            x_d = res;
                            if (CT || e_bit) begin
                                state_d = MUL;
                            end else if (bit_q == '0) begin
                                state_d = FROMMONT;
                            end else begin
                                bit_d   = bit_q - BW'(1);
                                state_d = SQR;
                            end
                        end
                        MUL: begin
                            // In constant-time mode a zero bit still costs a product, which is dropped here
                            if (e_bit) x_d = res;
                            if (bit_q == '0) begin
                                state_d = FROMMONT;
                            end else begin
                                bit_d   = bit_q - BW'(1);
                                state_d = SQR;
                            end
                        end
                        FROMMONT: begin
                            c_d     = res;
                            state_d = FIN;
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
            FIN: begin
                eoc_d   = 1'b1;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            c_q     <= '0;
            eoc_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (en) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            c_q     <= c_d;
            eoc_q   <= eoc_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            p_q    <= p_d;
            e_q    <= e_d;
            m_q    <= m_d;
            r2_q   <= r2_d;
            mbar_q <= mbar_d;
            x_q    <= x_d;
            u_q    <= u_d;
        end
    end

    assign c    = c_q;
    assign eoc  = eoc_q & en;
    assign done = done_q;
    assign busy = busy_q;
    assign err  = err_q;

endmodule

// File: tb/tb_modexp_mont.sv
// Scoreboard bench for modexp_mont: WIDTH=8 instance for the main checks, WIDTH=4 instance for the small directed case.
module tb_modexp_mont;

`ifdef MODEXP_CT_EN
    localparam bit CT = 1'b1;
`else
    localparam bit CT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en;
    logic       start8;
    logic [7:0] p8, e8, m8, r8, c8;
    logic       eoc8, done8, busy8, err8;
    logic       start4;
    logic [3:0] p4, e4, m4, r4, c4;
    logic       eoc4, done4, busy4, err4;

    modexp_mont #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .en(en), .start(start8),
        .p(p8), .e(e8), .m(m8), .const_r2(r8),
        .c(c8), .eoc(eoc8), .done(done8), .busy(busy8), .err(err8)
    );

    modexp_mont #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .start(start4),
        .p(p4), .e(e4), .m(m4), .const_r2(r4),
        .c(c4), .eoc(eoc4), .done(done4), .busy(busy4), .err(err4)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] c;
        logic       err;
    } exp_t;
    exp_t sb[$];
    exp_t got_e;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int popc(input logic [7:0] v);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic logic [7:0] model(input logic [7:0] mm, input logic [7:0] ee, input logic [7:0] pp);
        longint r, b;
        r = 1 % longint'(pp);
        b = longint'(mm) % longint'(pp);
        for (int i = 7; i >= 0; i--) begin
            r = (r * r) % longint'(pp);
            if (ee[i]) r = (r * b) % longint'(pp);
        end
        return 8'(r);
    endfunction

    function automatic int n_prod8(input logic [7:0] ee);
        return CT ? (3 + 16) : (3 + 8 + popc(ee));
    endfunction

    always @(negedge clk) begin
        if (eoc8 === 1'b1) begin
            if (sb.size() == 0) begin
                check_val("spurious_eoc", eoc8, 0);
            end else begin
                got_e = sb.pop_front();
                check_val("result_c", c8, got_e.c);
                check_val("result_err", err8, got_e.err);
                check_val("done_at_eoc", done8, 1);
                check_val("busy_at_eoc", busy8, 0);
            end
        end
    end

    task automatic run8(input logic [7:0] pp, input logic [7:0] ee, input logic [7:0] mm,
                        input logic [7:0] rr, input bit pulse_mid);
        bit         ex_err;
        int         exp_k, k;
        logic [7:0] ec;
        exp_t       ent;
        ex_err = (pp[0] == 1'b0) || (pp < 8'd3) || (rr >= pp);
        ec     = ex_err ? 8'd0 : model(mm, ee, pp);
        exp_k  = ex_err ? 2 : n_prod8(ee) * 9 + 2;
        ent.c   = ec;
        ent.err = ex_err;
        sb.push_back(ent);
        p8 = pp; e8 = ee; m8 = mm; r8 = rr;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        check_val("busy_after_start", busy8, 1);
        check_val("done_cleared", done8, 0);
        check_val("err_cleared", err8, 0);
        p8 = 8'($urandom); e8 = 8'($urandom); m8 = 8'($urandom); r8 = 8'($urandom);
        k = 0;
        for (int i = 1; i <= 2000; i++) begin
            @(posedge clk); #1;
            start8 = 1'b0;
            if (eoc8) begin
                k = i;
                break;
            end
            if (pulse_mid && i == 10) start8 = 1'b1;
        end
        check_val("latency", k, exp_k);
    endtask

    initial begin
        logic [7:0] pp, rr;
        int         k;
        bit         busy_ok;
        exp_t       ent;

        rst = 1'b1; en = 1'b1;
        start8 = 1'b0; p8 = '0; e8 = '0; m8 = '0; r8 = '0;
        start4 = 1'b0; p4 = '0; e4 = '0; m4 = '0; r4 = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_c", c8, 0);
        check_val("rst_eoc", eoc8, 0);
        check_val("rst_done", done8, 0);
        check_val("rst_busy", busy8, 0);
        check_val("rst_err", err8, 0);
        check_val("rst_c4", c4, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // WIDTH=4: 7^5 mod 13 = 11
        p4 = 4'd13; e4 = 4'd5; m4 = 4'd7; r4 = 4'd9;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        busy_ok = 1'b1;
        k = 0;
        for (int i = 1; i <= 500; i++) begin
            @(posedge clk); #1;
            if (eoc4) begin
                k = i;
                break;
            end
            if (!busy4) busy_ok = 1'b0;
        end
        check_val("w4_c", c4, 11);
        check_val("w4_latency", k, CT ? 57 : 47);
        check_val("w4_busy_during", busy_ok, 1);
        check_val("w4_busy_end", busy4, 0);
        check_val("w4_done", done4, 1);
        check_val("w4_err", err4, 0);
        @(posedge clk); #1;
        check_val("w4_eoc_pulse", eoc4, 0);

        // Zero exponent
        run8(8'd251, 8'd0, 8'd200, 8'd25, 1'b0);
        // Even modulus, then a valid request back-to-back that clears err
        run8(8'd12, 8'd5, 8'd7, 8'd4, 1'b0);
        run8(8'd13, 8'd5, 8'd7, 8'd3, 1'b0);
        // Modulus below 3, const not reduced
        run8(8'd1, 8'd3, 8'd7, 8'd0, 1'b0);
        run8(8'd13, 8'd5, 8'd7, 8'd13, 1'b0);
        // Base above modulus, all-ones exponent
        run8(8'd13, 8'hFF, 8'd250, 8'd3, 1'b0);
        run8(8'd251, 8'd0, 8'd200, 8'd25, 1'b0);

        // Reset mid-run with an extra start pulse before it
        p8 = 8'd251; e8 = 8'hA5; m8 = 8'd77; r8 = 8'd25;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        for (int i = 1; i <= 22; i++) begin
            @(posedge clk); #1;
            start8 = (i == 5);
        end
        start8 = 1'b0;
        check_val("busy_before_rst", busy8, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_val("midrst_c", c8, 0);
        check_val("midrst_eoc", eoc8, 0);
        check_val("midrst_done", done8, 0);
        check_val("midrst_busy", busy8, 0);
        check_val("midrst_err", err8, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        run8(8'd251, 8'hA5, 8'd77, 8'd25, 1'b0);

        // Clock enable low for 7 edges inside the first MUL
        ent.c   = model(8'd200, 8'hFF, 8'd239);
        ent.err = 1'b0;
        sb.push_back(ent);
        p8 = 8'd239; e8 = 8'hFF; m8 = 8'd200; r8 = 8'(65536 % 239);
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        k = 0;
        for (int i = 1; i <= 2000; i++) begin
            @(posedge clk); #1;
            if (!en) check_val("eoc_while_en_low", eoc8, 0);
            if (eoc8) begin
                k = i;
                break;
            end
            en = !(i >= 30 && i < 37);
        end
        en = 1'b1;
        check_val("en_latency", k, n_prod8(8'hFF) * 9 + 2 + 7);

        // Random sweep, one run with an ignored mid-run start
        for (int t = 0; t < 16; t++) begin
            pp = 8'($urandom_range(127, 1) * 2 + 1);
            rr = 8'(65536 % int'(pp));
            run8(pp, 8'($urandom), 8'($urandom), rr, t == 3);
        end

        repeat (4) @(posedge clk);
        #1;
        check_val("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
